// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg -- shared definitions for the execution unit and the CPU.
//   Opcode encoding, instruction field positions and field widths.
//   No ports; imported with "import exec_unit_pkg::*;".
package exec_unit_pkg;

   // Instruction field positions within the 16-bit instruction word
   localparam int OPC_MSB   = 15;
   localparam int OPC_LSB   = 11;
   localparam int RX_MSB    = 10;
   localparam int RX_LSB    = 8;
   localparam int RY_MSB    = 7;
   localparam int RY_LSB    = 5;
   localparam int IMM_MSB   = 7;
   localparam int IMM_LSB   = 0;

   // Field widths
   localparam int OPC_W     = OPC_MSB - OPC_LSB + 1;
   localparam int REG_IDX_W = RX_MSB - RX_LSB + 1;
   localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;
   localparam int FLAG_W    = 3;   // {N,Z,C}

   typedef enum logic [OPC_W-1:0] {
      OP_ADD   = 5'b00001,
      OP_ADC   = 5'b00010,
      OP_SUB   = 5'b00011,
      OP_AND   = 5'b00100,
      OP_OR    = 5'b00101,
      OP_XOR   = 5'b00110,
      OP_CMP   = 5'b00111,
      OP_MOV   = 5'b01000,
      OP_STR   = 5'b10000,
      OP_LOAD  = 5'b10001,
      OP_RSTR  = 5'b10010,
      OP_RLOAD = 5'b10011,
      OP_JMP   = 5'b10100,
      OP_JC    = 5'b10101,
      OP_JZ    = 5'b10110,
      OP_JN    = 5'b10111,
      OP_INC   = 5'b11000,
      OP_DEC   = 5'b11001,
      OP_SHR   = 5'b11010,
      OP_SHL   = 5'b11011,
      OP_SET   = 5'b11111
   } opcode_e;

endpackage

// File: rtl/exec_dmem.sv
// exec_dmem -- data memory, 2^ADDR_SIZE x WORD_SIZE.
//   Synchronous write on rising clk, asynchronous (combinational) read.
//   Contents are never cleared; a read of the address being written in the
//   same cycle returns the old contents.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (same cycle)
module exec_dmem #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] waddr,
   input  logic [WORD_SIZE-1:0] wdata,
   input  logic [ADDR_SIZE-1:0] raddr,
   output logic [WORD_SIZE-1:0] rdata
);

   logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/exec_unit.sv
// exec_unit -- single-cycle execute stage: decode, ALU, flag register,
//   branch resolution and data memory access.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (clears flags only)
//   inst       in   current instruction
//   rx_val     in   register-file value of Rx
//   ry_val     in   register-file value of Ry
//   idx_rx     out  Rx index, inst[10:8]
//   idx_ry     out  Ry index, inst[7:5]
//   reg_wdata  out  register write data (0 when no write)
//   reg_widx   out  register write index (0 when no write)
//   reg_we     out  register write enable
//   br_taken   out  jump taken this cycle
//   br_target  out  jump target (imm)
//   flags      out  {N,Z,C} flag register
//   illegal    out  undefined opcode
module exec_unit
   import exec_unit_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 8,
   parameter int INST_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INST_SIZE-1:0] inst,
   input  logic [WORD_SIZE-1:0] rx_val,
   input  logic [WORD_SIZE-1:0] ry_val,
   output logic [REG_IDX_W-1:0] idx_rx,
   output logic [REG_IDX_W-1:0] idx_ry,
   output logic [WORD_SIZE-1:0] reg_wdata,
   output logic [REG_IDX_W-1:0] reg_widx,
   output logic                 reg_we,
   output logic                 br_taken,
   output logic [IMM_W-1:0]     br_target,
   output logic [FLAG_W-1:0]    flags,
   output logic                 illegal
);

   localparam int EXT_W = WORD_SIZE + 1;

   logic [OPC_W-1:0]     opc;
   logic [IMM_W-1:0]     imm;

   // ext carries the ALU result in its low WORD_SIZE bits and the carry,
   // borrow or shifted-out bit in its MSB, so C is always ext[WORD_SIZE].
   logic [EXT_W-1:0]     ext;
   logic                 flag_upd;
   logic                 src_alu;
   logic                 wr_en;
   logic [WORD_SIZE-1:0] wr_val;

   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [ADDR_SIZE-1:0] mem_raddr;
   logic [WORD_SIZE-1:0] mem_rdata;

   assign opc       = inst[OPC_MSB:OPC_LSB];
   assign imm       = inst[IMM_MSB:IMM_LSB];
   assign idx_rx    = inst[RX_MSB:RX_LSB];
   assign idx_ry    = inst[RY_MSB:RY_LSB];
   assign br_target = imm;

   always_comb begin
      ext       = '0;
      flag_upd  = 1'b0;
      src_alu   = 1'b0;
      wr_en     = 1'b0;
      wr_val    = '0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_raddr = '0;
      br_taken  = 1'b0;
      illegal   = 1'b0;

      case (opc)
         OP_ADD: begin
            ext = {1'b0, rx_val} + {1'b0, ry_val};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_ADC: begin
            ext = {1'b0, rx_val} + {1'b0, ry_val} + EXT_W'(flags[0]);
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_SUB: begin
            ext = {1'b0, rx_val} - {1'b0, ry_val};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_AND: begin
            ext = {1'b0, rx_val & ry_val};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_OR: begin
            ext = {1'b0, rx_val | ry_val};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_XOR: begin
            ext = {1'b0, rx_val ^ ry_val};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_CMP: begin
            // Same subtraction as SUB, flags only
            ext = {1'b0, rx_val} - {1'b0, ry_val};
            flag_upd = 1'b1;
         end
         OP_MOV: begin
            ext = {1'b0, ry_val};
            src_alu = 1'b1;
         end
         OP_INC: begin
            ext = {1'b0, rx_val} + EXT_W'(1);
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_DEC: begin
            // 0 - 1 wraps the extended word, setting the borrow bit
            ext = {1'b0, rx_val} - EXT_W'(1);
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_SHR: begin
            ext = {rx_val[0], 1'b0, rx_val[WORD_SIZE-1:1]};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_SHL: begin
            ext = {rx_val, 1'b0};
            flag_upd = 1'b1; src_alu = 1'b1;
         end
         OP_SET: begin
            wr_en  = 1'b1;
            wr_val = WORD_SIZE'(imm);
         end
         OP_LOAD: begin
            mem_raddr = ADDR_SIZE'(imm);
            wr_en     = 1'b1;
            wr_val    = mem_rdata;
         end
         OP_RLOAD: begin
            mem_raddr = ADDR_SIZE'(ry_val);
            wr_en     = 1'b1;
            wr_val    = mem_rdata;
         end
         OP_STR: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_SIZE'(imm);
            mem_wdata = rx_val;
         end
         OP_RSTR: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_SIZE'(rx_val);
            mem_wdata = ry_val;
         end
         OP_JMP:  br_taken = 1'b1;
         OP_JC:   br_taken = flags[0];
         OP_JZ:   br_taken = flags[1];
         OP_JN:   br_taken = flags[2];
         default: illegal  = 1'b1;
      endcase

      if (src_alu) begin
         wr_en  = 1'b1;
         wr_val = ext[WORD_SIZE-1:0];
      end
   end

   assign reg_we    = wr_en;
   assign reg_wdata = wr_en ? wr_val : '0;
   assign reg_widx  = wr_en ? idx_rx : '0;

   // Flag register boundary: {N,Z,C} from the extended ALU word
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
      end else if (flag_upd) begin
         flags <= {ext[WORD_SIZE-1], (ext[WORD_SIZE-1:0] == '0), ext[WORD_SIZE]};
      end
   end

   // Memory contents survive reset; only the write is blocked while rst=1
   exec_dmem #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we & ~rst),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit -- directed and randomized bench for exec_unit against an
//   arithmetic reference model of the instruction set.
module tb_exec_unit;

   logic        clk;
   logic        rst;
   logic [15:0] inst;
   logic [7:0]  rx_val;
   logic [7:0]  ry_val;
   logic [2:0]  idx_rx;
   logic [2:0]  idx_ry;
   logic [7:0]  reg_wdata;
   logic [2:0]  reg_widx;
   logic        reg_we;
   logic        br_taken;
   logic [7:0]  br_target;
   logic [2:0]  flags;
   logic        illegal;

   exec_unit #(
      .WORD_SIZE (8),
      .ADDR_SIZE (8),
      .INST_SIZE (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .inst      (inst),
      .rx_val    (rx_val),
      .ry_val    (ry_val),
      .idx_rx    (idx_rx),
      .idx_ry    (idx_ry),
      .reg_wdata (reg_wdata),
      .reg_widx  (reg_widx),
      .reg_we    (reg_we),
      .br_taken  (br_taken),
      .br_target (br_target),
      .flags     (flags),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [7:0] mem_m [256];
   bit         mf_n, mf_z, mf_c;

   // Values observed at the last step, for directed spot checks
   logic [7:0] last_wdata;
   logic       last_we;
   logic       last_br;
   logic       last_ill;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int rx, input int lo);
      logic [15:0] w;
      w = {5'(op), 3'(rx), 8'(lo)};
      return w;
   endfunction

   // One instruction: drive, check combinational outputs mid-cycle, clock,
   // then check the flag register. Caller is just after a rising edge.
   task automatic step(input logic [15:0] i, input logic [7:0] a_in, input logic [7:0] b_in);
      int  op, a, b, imm, r;
      bit  ill, wr, upd, br, cy, mw;
      int  wval, maddr, mdata;

      inst = i; rx_val = a_in; ry_val = b_in;
      op = int'(i[15:11]); a = int'(a_in); b = int'(b_in); imm = int'(i[7:0]);
      ill = 0; wr = 0; upd = 0; br = 0; cy = 0; mw = 0;
      r = 0; wval = 0; maddr = 0; mdata = 0;

      case (op)
         1:  begin r = a + b;          cy = (r > 255); upd = 1; wr = 1; end
         2:  begin r = a + b + int'(mf_c); cy = (r > 255); upd = 1; wr = 1; end
         3:  begin r = a - b;          cy = (a < b);   upd = 1; wr = 1; end
         4:  begin r = a & b;                          upd = 1; wr = 1; end
         5:  begin r = a | b;                          upd = 1; wr = 1; end
         6:  begin r = a ^ b;                          upd = 1; wr = 1; end
         7:  begin r = a - b;          cy = (a < b);   upd = 1;         end
         8:  begin r = b;                                       wr = 1; end
         24: begin r = a + 1;          cy = (r > 255); upd = 1; wr = 1; end
         25: begin r = a - 1;          cy = (a == 0);  upd = 1; wr = 1; end
         26: begin r = a / 2;          cy = (a % 2 == 1); upd = 1; wr = 1; end
         27: begin r = a * 2;          cy = (r > 255); upd = 1; wr = 1; end
         31: begin r = imm;                                     wr = 1; end
         17: begin r = int'(mem_m[imm]);                        wr = 1; end
         19: begin r = int'(mem_m[b]);                          wr = 1; end
         16: begin mw = 1; maddr = imm; mdata = a; end
         18: begin mw = 1; maddr = a;   mdata = b; end
         20: br = 1;
         21: br = mf_c;
         22: br = mf_z;
         23: br = mf_n;
         default: ill = 1;
      endcase
      wval = ((r % 256) + 256) % 256;

      @(negedge clk);
      last_wdata = reg_wdata; last_we = reg_we; last_br = br_taken; last_ill = illegal;
      chk("illegal",   illegal,   32'(ill));
      chk("reg_we",    reg_we,    32'(wr));
      chk("reg_wdata", reg_wdata, wr ? 32'(wval) : 32'd0);
      chk("reg_widx",  reg_widx,  wr ? 32'(i[10:8]) : 32'd0);
      chk("br_taken",  br_taken,  32'(br));
      chk("br_target", br_target, 32'(imm));
      chk("idx_rx",    idx_rx,    32'(i[10:8]));
      chk("idx_ry",    idx_ry,    32'(i[7:5]));

      @(posedge clk);
      #1;
      if (rst) begin
         mf_n = 0; mf_z = 0; mf_c = 0;
      end else begin
         if (mw) mem_m[maddr] = 8'(mdata);
         if (upd) begin
            mf_n = (wval >= 128); mf_z = (wval == 0); mf_c = cy;
         end
      end
      chk("flags", flags, {29'd0, mf_n, mf_z, mf_c});
   endtask

   initial begin
      logic [7:0] rv;
      rst = 1'b1; inst = '0; rx_val = '0; ry_val = '0;
      mf_n = 0; mf_z = 0; mf_c = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flags", flags, 32'd0);
      rst = 1'b0;

      // Fill memory so every later read has a known reference value
      for (int k = 0; k < 256; k++) begin
         rv = 8'($urandom);
         step(mk(16, 0, k), rv, 8'h00);
      end

      // ADD wraps to zero with carry
      step(mk(1, 1, 8'h40), 8'hFF, 8'h01);
      chk("add_wdata", last_wdata, 32'h00);
      chk("add_we",    last_we,    32'd1);
      chk("add_flags", flags,      32'b011);
      // ADC consumes the carry
      step(mk(2, 2, 8'h60), 8'h10, 8'h20);
      chk("adc_wdata", last_wdata, 32'h31);
      chk("adc_flags", flags,      32'b000);
      // CMP then JN
      step(mk(7, 3, 8'h80), 8'h05, 8'h07);
      chk("cmp_we",    last_we,    32'd0);
      chk("cmp_flags", flags,      32'b101);
      step(mk(23, 0, 8'h40), 8'h00, 8'h00);
      chk("jn_taken",  last_br,    32'd1);
      // STR / LOAD
      step(mk(16, 4, 8'h10), 8'hAB, 8'h00);
      step(mk(17, 5, 8'h10), 8'h00, 8'h00);
      chk("load_wdata", last_wdata, 32'hAB);
      // RSTR / RLOAD via address 0x20
      step(mk(18, 1, 8'h20), 8'h20, 8'h5C);
      step(mk(19, 2, 8'h20), 8'h00, 8'h20);
      chk("rload_wdata", last_wdata, 32'h5C);
      // Shifts
      step(mk(27, 3, 8'h00), 8'h81, 8'h00);
      chk("shl_wdata", last_wdata, 32'h02);
      chk("shl_flags", flags,      32'b001);
      step(mk(26, 3, 8'h00), 8'h01, 8'h00);
      chk("shr_wdata", last_wdata, 32'h00);
      chk("shr_flags", flags,      32'b011);
      // DEC from zero borrows
      step(mk(25, 6, 8'h00), 8'h00, 8'h00);
      chk("dec_wdata", last_wdata, 32'hFF);
      chk("dec_flags", flags,      32'b101);
      // Illegal opcode: no writes, flags untouched
      step(mk(15, 1, 8'h10), 8'h77, 8'h00);
      chk("ill_flag",  last_ill,   32'd1);
      chk("ill_we",    last_we,    32'd0);
      chk("ill_flags", flags,      32'b101);
      step(mk(17, 1, 8'h10), 8'h00, 8'h00);
      chk("ill_mem",   last_wdata, 32'hAB);
      // Reset clears flags but blocks the store and keeps memory
      rst = 1'b1;
      step(mk(16, 1, 8'h10), 8'h11, 8'h00);
      chk("rst_flags", flags, 32'b000);
      rst = 1'b0;
      step(mk(17, 1, 8'h10), 8'h00, 8'h00);
      chk("rst_mem",   last_wdata, 32'hAB);

      // Randomized instruction stream
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         step({5'($urandom_range(0, 31)), 11'($urandom)}, 8'($urandom), 8'($urandom));
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst is synchronous and active-high.
REQ-002 Parameter WORD_SIZE, default 8, SHALL set the data word width.
REQ-003 Parameter ADDR_SIZE, default 8, SHALL set the data-memory address width (2^ADDR_SIZE words).
REQ-004 Parameter INST_SIZE, default 16, SHALL set the instruction width.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- inst  in  16  current instruction
- rx_val  in  8  register-file value of Rx
- ry_val  in  8  register-file value of Ry
- idx_rx  out  3  inst[10:8]
- idx_ry  out  3  inst[7:5]
- reg_wdata  out  8  register write data
- reg_widx  out  3  register write index
- reg_we  out  1  register write enable
- br_taken  out  1  jump taken this cycle
- br_target  out  8  jump target (imm)
- flags  out  3  {N,Z,C} flag register
- illegal  out  1  undefined opcode

Function
REQ-006 Decode SHALL be combinational: opcode=inst[15:11], Rx=inst[10:8], Ry=inst[7:5], imm=inst[7:0].
REQ-007 Opcodes SHALL be: ADD 00001, ADC 00010, SUB 00011, AND 00100, OR 00101, XOR 00110, CMP 00111, MOV 01000, STR 10000, LOAD 10001, RSTR 10010, RLOAD 10011, JMP 10100, JC 10101, JZ 10110, JN 10111, INC 11000, DEC 11001, SHR 11010, SHL 11011, SET 11111; all others SHALL assert illegal.
REQ-008 ALU results (a=rx_val, b=ry_val, 8-bit, wrap modulo 256) SHALL be: ADD a+b; ADC a+b+C; SUB and CMP a-b; AND/OR/XOR bitwise; MOV b; INC a+1; DEC a-1; SHR logical a>>1; SHL a<<1.
REQ-009 ADD/ADC/SUB/AND/OR/XOR/MOV/INC/DEC/SHR/SHL SHALL drive reg_wdata=ALU result, reg_widx=Rx, reg_we=1; CMP SHALL NOT write (reg_we=0).
REQ-010 Flags SHALL update on the clock edge only for ALU ops except MOV: Z=(result==0), N=result[7]; C=carry-out for ADD/ADC/INC, borrow (a<b, or a==0 for DEC) for SUB/CMP/DEC, shifted-out bit for SHR/SHL, 0 for AND/OR/XOR.
REQ-011 SET SHALL write imm to Rx; LOAD SHALL write Mem[imm] to Rx; RLOAD SHALL write Mem[ry_val] to Rx; memory read SHALL be combinational (same cycle).
REQ-012 STR SHALL write rx_val to Mem[imm]; RSTR SHALL write ry_val to Mem[rx_val]; memory writes SHALL occur on the rising clk edge.
REQ-013 br_target SHALL equal imm; br_taken SHALL be 1 for JMP, for JC when C=1, JZ when Z=1, JN when N=1, else 0; jumps SHALL not write registers, memory or flags.
REQ-014 When illegal=1 or opcode=00000, reg_we, memory write and flag update SHALL all be suppressed.
REQ-015 With no write active, reg_wdata and reg_widx SHALL be 0.
REQ-016 A LOAD from an address written in the same cycle SHALL return the old contents.

Reset
REQ-017 On rst at a rising edge flags SHALL become 3'b000; combinational outputs follow inst.
REQ-018 Memory contents SHALL NOT be cleared by rst; writes SHALL be suppressed while rst=1.

Structure
REQ-019 Opcode enum, field positions and width constants SHALL live in a shared package used by exec_unit and the CPU.
REQ-020 The data memory SHALL be a sub-module exec_dmem (2^ADDR_SIZE x WORD_SIZE, sync write, async read); decode and ALU are inline.

Verification
REQ-021 ADD Rx=0xFF, Ry=0x01 -> reg_wdata=0x00, reg_we=1, next flags {N,Z,C}=011.
REQ-022 ADC after REQ-021 with 0x10+0x20 -> reg_wdata=0x31, flags=000.
REQ-023 CMP 0x05,0x07 -> reg_we=0, flags=101; then JN 0x40 -> br_taken=1, br_target=0x40.
REQ-024 STR rx_val=0xAB imm=0x10, next cycle LOAD imm=0x10 -> reg_wdata=0xAB; RSTR/RLOAD via 0x20 likewise.
REQ-025 SHL 0x81 -> reg_wdata=0x02, C=1; SHR 0x01 -> 0x00, Z=1, C=1.
REQ-026 Opcode 01111 -> illegal=1, no writes; rst asserted -> flags=000 next edge, memory retained.
